// File: rtl/vga_sync_gen_pkg.sv
// Shared raster constants and phase encoding for the VGA sync path.
// XGA (1024x768) timing defaults; the downstream display-enable stage uses the same values.
package vga_sync_gen_pkg;

  localparam int XGA_H_RES  = 1024;
  localparam int XGA_H_FP   = 24;
  localparam int XGA_H_SYNC = 136;
  localparam int XGA_H_BP   = 160;
  localparam int XGA_V_RES  = 768;
  localparam int XGA_V_FP   = 3;
  localparam int XGA_V_SYNC = 6;
  localparam int XGA_V_BP   = 29;

  // Total pixels (or lines) spanned by one axis period.
  function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

  localparam int XGA_H_TOTAL = axis_total(XGA_H_RES, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
  localparam int XGA_V_TOTAL = axis_total(XGA_V_RES, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);

  // Raster phase of one axis; encodings are shared with the enable stage.
  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
// The phase register always describes the position held in the count register.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int RES  = XGA_H_RES,
  parameter int FP   = XGA_H_FP,
  parameter int SYNC = XGA_H_SYNC,
  parameter int BP   = XGA_H_BP,
  parameter int DIM  = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,       // advance one position this cycle
  output logic         wrap,       // count sits on the last position of the period
  output logic [DIM:0] count,
  output phase_t       phase,
  output phase_t       phase_nxt   // phase that goes with the next count value
);

  localparam int TOTAL = axis_total(RES, FP, SYNC, BP);
  localparam logic [DIM:0] LAST       = (DIM+1)'(TOTAL - 1);
  localparam logic [DIM:0] FP_START   = (DIM+1)'(RES);
  localparam logic [DIM:0] SYNC_START = (DIM+1)'(RES + FP);
  localparam logic [DIM:0] BP_START   = (DIM+1)'(RES + FP + SYNC);
  localparam logic [DIM:0] ONE        = (DIM+1)'(1);

  logic [DIM:0] count_nxt;

  assign wrap = (count == LAST);

  // Next count: hold, increment, or wrap to zero at the end of the period.
  always_comb begin
    count_nxt = count;
    if (step) begin
      count_nxt = wrap ? '0 : count + ONE;
    end
  end

  // Phase FSM transitions, decoded on the next count so phase and count stay aligned.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_ACT:  if (count_nxt == FP_START)   phase_nxt = PH_FP;
      PH_FP:   if (count_nxt == SYNC_START) phase_nxt = PH_SYNC;
      PH_SYNC: if (count_nxt == BP_START)   phase_nxt = PH_BP;
      PH_BP:   if (count_nxt == '0)         phase_nxt = PH_ACT;
    endcase
  end

  // Count and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_ACT;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: H/V pixel counters, HSYNC/VSYNC and line/frame strobes.
// EN is a plain advance qualifier (no handshake): when high the raster moves one pixel per
// PIX_CLK edge; when low every register holds and both strobes read 0.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   H_RES  = XGA_H_RES,
  parameter int   H_FP   = XGA_H_FP,
  parameter int   H_SYNC = XGA_H_SYNC,
  parameter int   H_BP   = XGA_H_BP,
  parameter int   V_RES  = XGA_V_RES,
  parameter int   V_FP   = XGA_V_FP,
  parameter int   V_SYNC = XGA_V_SYNC,
  parameter int   V_BP   = XGA_V_BP,
  parameter int   H_DIM  = 11,
  parameter int   V_DIM  = 10,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic             PIX_CLK,
  input  logic             RST_N,
  input  logic             EN,
  output logic [H_DIM:0]   HORIZONTAL,
  output logic [V_DIM:0]   VERTICAL,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             LINE_END,
  output logic             FRAME_END
);

  logic   h_wrap;
  logic   v_wrap;
  logic   v_step;
  phase_t h_phase;
  phase_t h_phase_nxt;
  phase_t v_phase;
  phase_t v_phase_nxt;

  // The vertical axis moves only when an enabled pixel leaves the last column.
  assign v_step = h_wrap && EN;

  vga_axis_counter #(
    .RES  (H_RES),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .DIM  (H_DIM)
  ) u_h_axis (
    .clk       (PIX_CLK),
    .rst_n     (RST_N),
    .step      (EN),
    .wrap      (h_wrap),
    .count     (HORIZONTAL),
    .phase     (h_phase),
    .phase_nxt (h_phase_nxt)
  );

  vga_axis_counter #(
    .RES  (V_RES),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .DIM  (V_DIM)
  ) u_v_axis (
    .clk       (PIX_CLK),
    .rst_n     (RST_N),
    .step      (v_step),
    .wrap      (v_wrap),
    .count     (VERTICAL),
    .phase     (v_phase),
    .phase_nxt (v_phase_nxt)
  );

  // Sync levels registered from the next-phase decode so they land with the counters.
  always_ff @(posedge PIX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      HSYNC <= ~HS_POL;
      VSYNC <= ~VS_POL;
    end else begin
      if (EN) begin
        HSYNC <= (h_phase_nxt == PH_SYNC) ? HS_POL : ~HS_POL;
      end
      if (v_step) begin
        VSYNC <= (v_phase_nxt == PH_SYNC) ? VS_POL : ~VS_POL;
      end
    end
  end

  // Strobes decoded straight off the registered counts.
  always_comb begin
    LINE_END  = EN && h_wrap;
    FRAME_END = EN && h_wrap && v_wrap;
  end

  // Each sync level must agree with the phase register of its axis.
  always_ff @(posedge PIX_CLK) begin
    if (RST_N) begin
      assert ((h_phase == PH_SYNC) == (HSYNC == HS_POL));
      assert ((v_phase == PH_SYNC) == (VSYNC == VS_POL));
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (XGA, tiny 8x6 with HS_POL=1, tiny-H/XGA-V).
// Driver pushes the expected raster word for every cycle; a negedge monitor pops and compares.
module tb_vga_sync_gen;

  // ---------------- clock / reset ----------------
  logic pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  logic [2:0] rst_n = 3'b000;
  logic [2:0] en    = 3'b000;

  logic [11:0] h0;  logic [10:0] v0;  logic hs0, vs0, le0, fe0;
  logic [2:0]  h1;  logic [2:0]  v1;  logic hs1, vs1, le1, fe1;
  logic [2:0]  h2;  logic [10:0] v2;  logic hs2, vs2, le2, fe2;

  vga_sync_gen u_dut0 (
    .PIX_CLK(pix_clk), .RST_N(rst_n[0]), .EN(en[0]),
    .HORIZONTAL(h0), .VERTICAL(v0), .HSYNC(hs0), .VSYNC(vs0),
    .LINE_END(le0), .FRAME_END(fe0)
  );

  vga_sync_gen #(
    .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_DIM(2), .V_DIM(2), .HS_POL(1'b1), .VS_POL(1'b0)
  ) u_dut1 (
    .PIX_CLK(pix_clk), .RST_N(rst_n[1]), .EN(en[1]),
    .HORIZONTAL(h1), .VERTICAL(v1), .HSYNC(hs1), .VSYNC(vs1),
    .LINE_END(le1), .FRAME_END(fe1)
  );

  vga_sync_gen #(
    .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .H_DIM(2)
  ) u_dut2 (
    .PIX_CLK(pix_clk), .RST_N(rst_n[2]), .EN(en[2]),
    .HORIZONTAL(h2), .VERTICAL(v2), .HSYNC(hs2), .VSYNC(vs2),
    .LINE_END(le2), .FRAME_END(fe2)
  );

  // Timing of each instance, written out by hand.
  int h_res [3] = '{1024, 4, 4};
  int h_fp  [3] = '{24,   1, 1};
  int h_syn [3] = '{136,  2, 2};
  int h_tot [3] = '{1344, 8, 8};
  int v_res [3] = '{768,  3, 768};
  int v_fp  [3] = '{3,    1, 3};
  int v_syn [3] = '{6,    1, 6};
  int v_tot [3] = '{806,  6, 806};
  logic h_pol [3] = '{1'b0, 1'b1, 1'b0};
  logic v_pol [3] = '{1'b0, 1'b0, 1'b0};

  // Bench model of the raster position.
  int mh [3] = '{0, 0, 0};
  int mv [3] = '{0, 0, 0};

  // ---------------- scoreboard ----------------
  // word: id[28:27] h[26:15] v[14:4] hsync[3] vsync[2] line_end[1] frame_end[0]
  logic [28:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int hs0_low_en = 0;
  int vs2_low = 0;
  int fe1_cnt = 0;
  string cur_test = "reset";

  function automatic logic [28:0] expect_word(input int d);
    logic hs, vs, le, fe;
    int hlo, vlo;
    hlo = h_res[d] + h_fp[d];
    vlo = v_res[d] + v_fp[d];
    hs = (mh[d] >= hlo && mh[d] < hlo + h_syn[d]) ? h_pol[d] : ~h_pol[d];
    vs = (mv[d] >= vlo && mv[d] < vlo + v_syn[d]) ? v_pol[d] : ~v_pol[d];
    le = en[d] && (mh[d] == h_tot[d] - 1);
    fe = le && (mv[d] == v_tot[d] - 1);
    return {2'(d), 12'(mh[d]), 11'(mv[d]), hs, vs, le, fe};
  endfunction

  // Monitor: compare the DUT named in each expected word against it.
  always @(negedge pix_clk) begin
    logic [28:0] w, a;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      case (w[28:27])
        2'd0:    a = {2'd0, h0,        v0,         hs0, vs0, le0, fe0};
        2'd1:    a = {2'd1, 12'(h1),   11'(v1),    hs1, vs1, le1, fe1};
        default: a = {2'd2, 12'(h2),   v2,         hs2, vs2, le2, fe2};
      endcase
      if (w[28:27] == 2'd0 && !hs0 && en[0]) hs0_low_en++;
      if (w[28:27] == 2'd2 && !vs2) vs2_low++;
      if (w[28:27] == 2'd1 && fe1) fe1_cnt++;
      total++;
      if (a !== w) begin
        bad++;
        $display("FAIL %s dut%0d h/v got %0d/%0d want %0d/%0d hs,vs,le,fe got %b%b%b%b want %b%b%b%b",
                 cur_test, w[28:27], a[26:15], a[14:4], w[26:15], w[14:4],
                 a[3], a[2], a[1], a[0], w[3], w[2], w[1], w[0]);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Queue the expectation for the current cycle, then step the model across the edge.
  task automatic tick(input int d);
    exp_q.push_back(expect_word(d));
    @(posedge pix_clk);
    #1;
    if (en[d] && rst_n[d]) begin
      if (mh[d] == h_tot[d] - 1) begin
        mh[d] = 0;
        mv[d] = (mv[d] == v_tot[d] - 1) ? 0 : mv[d] + 1;
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
  endtask

  task automatic run(input int d, input int n, input logic e);
    en[d] = e;
    for (int i = 0; i < n; i++) tick(d);
  endtask

  task automatic set_rst(input int d, input logic r);
    rst_n[d] = r;
    if (!r) begin
      mh[d] = 0;
      mv[d] = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge pix_clk);
    #1;

    // XGA instance: reset state, then one full line.
    cur_test = "xga_reset";
    run(0, 2, 1'b1);
    set_rst(0, 1'b1);
    cur_test = "xga_line";
    hs0_low_en = 0;
    run(0, 1344, 1'b1);
    check_lit("xga_line_h", int'(h0), 0);
    check_lit("xga_line_v", int'(v0), 1);
    check_lit("xga_hsync_width", hs0_low_en, 136);

    // Freeze for 50 cycles inside the sync pulse at H=1100.
    cur_test = "xga_en_freeze";
    hs0_low_en = 0;
    run(0, 1100, 1'b1);
    run(0, 50, 1'b0);
    check_lit("xga_freeze_h", int'(h0), 1100);
    run(0, 244, 1'b1);
    check_lit("xga_freeze_hsync_width", hs0_low_en, 136);
    check_lit("xga_freeze_v", int'(v0), 2);

    // Async reset in the middle of the sync pulse.
    cur_test = "xga_mid_reset";
    run(0, 1150, 1'b1);
    set_rst(0, 1'b0);
    #1;
    check_lit("xga_rst_h", int'(h0), 0);
    check_lit("xga_rst_hsync", int'(hs0), 1);
    run(0, 3, 1'b1);
    set_rst(0, 1'b1);
    run(0, 10, 1'b1);
    en[0] = 1'b0;

    // Tiny raster: 8 pixels x 6 lines, FRAME_END every 48 enabled clocks.
    cur_test = "tiny_frames";
    fe1_cnt = 0;
    run(1, 2, 1'b1);
    set_rst(1, 1'b1);
    run(1, 149, 1'b1);
    check_lit("tiny_frame_end_count", fe1_cnt, 3);
    en[1] = 1'b0;

    // Short lines, XGA vertical timing: a whole frame plus the vertical wrap.
    cur_test = "vtiming_frame";
    vs2_low = 0;
    run(2, 2, 1'b1);
    set_rst(2, 1'b1);
    run(2, 6448 + 20, 1'b1);
    check_lit("vtiming_vsync_cycles", vs2_low, 48);
    check_lit("vtiming_wrap_v", int'(v2), 2);

    // Reset with both syncs active at V=773, H=5.
    cur_test = "vtiming_mid_reset";
    set_rst(2, 1'b0);
    run(2, 1, 1'b1);
    set_rst(2, 1'b1);
    run(2, 773 * 8 + 5, 1'b1);
    check_lit("vtiming_pre_rst_vsync", int'(vs2), 0);
    check_lit("vtiming_pre_rst_hsync", int'(hs2), 0);
    set_rst(2, 1'b0);
    #1;
    check_lit("vtiming_rst_vsync", int'(vs2), 1);
    check_lit("vtiming_rst_v", int'(v2), 0);
    run(2, 2, 1'b1);
    set_rst(2, 1'b1);
    run(2, 5, 1'b1);
    en[2] = 1'b0;

    @(negedge pix_clk);
    #1;
    check_lit("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
